// File: rtl/trap_csr_pkg.sv
// ---------------------------------------------------------------------------
// trap_csr_pkg
// Shared constants for the machine-mode trap CSR block: CSR addresses,
// mcause codes, mstatus bit positions and a helper that assembles the
// architecturally visible mstatus word from the two implemented bits.
// ---------------------------------------------------------------------------
package trap_csr_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS     = 12'h300;
   localparam logic [11:0] CSR_MTVEC       = 12'h305;
   localparam logic [11:0] CSR_MEPC        = 12'h341;
   localparam logic [11:0] CSR_MCAUSE      = 12'h342;
   localparam logic [11:0] CSR_MTIMECMP_LO = 12'h7C0;
   localparam logic [11:0] CSR_MTIMECMP_HI = 12'h7C1;
   localparam logic [11:0] CSR_TIME        = 12'hC01;
   localparam logic [11:0] CSR_TIMEH       = 12'hC81;

   // mcause codes
   localparam logic [31:0] EXC_ILLEGAL = 32'h0000_0002;
   localparam logic [31:0] EXC_ECALL_M = 32'h0000_000B;
   localparam logic [31:0] INT_EXT_M   = 32'h8000_000B;
   localparam logic [31:0] INT_TIMER_M = 32'h8000_0007;

   // mstatus layout
   localparam int          MSTATUS_MIE_BIT  = 3;
   localparam int          MSTATUS_MPIE_BIT = 7;
   localparam int          MSTATUS_MPP_LSB  = 11;
   localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

   // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] w;
      w = '0;
      w[MSTATUS_MIE_BIT]                    = mie;
      w[MSTATUS_MPIE_BIT]                   = mpie;
      w[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]  = MSTATUS_MPP_M;
      return w;
   endfunction

endpackage

// File: rtl/trap_csr_unit_frc_timer.sv
// ---------------------------------------------------------------------------
// frc_timer
// 64-bit free-running counter (mtime) with a 64-bit compare register
// (mtimecmp) and a registered unsigned "mtimecmp <= mtime" flag.
// Reading the low half of time snapshots the high half so a following
// timeh read returns a value coherent with the earlier low read.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_cmp_lo_we     write mtimecmp[31:0]  with i_wdata
//   i_cmp_hi_we     write mtimecmp[63:32] with i_wdata
//   i_wdata         write data
//   i_snap_re       capture mtime[63:32] into the timeh snapshot
//   o_mtime_lo      live mtime[31:0]
//   o_timeh_snap    captured mtime[63:32]
//   o_mtimecmp      current mtimecmp
//   o_leq           registered (mtimecmp <= mtime)
// ---------------------------------------------------------------------------
module frc_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_cmp_lo_we,
   input  logic        i_cmp_hi_we,
   input  logic [31:0] i_wdata,
   input  logic        i_snap_re,
   output logic [31:0] o_mtime_lo,
   output logic [31:0] o_timeh_snap,
   output logic [63:0] o_mtimecmp,
   output logic        o_leq
);

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic [31:0] r_timeh_snap;
   logic        r_leq;

   // Counter wraps naturally from all-ones to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtime <= '0;
      end else begin
         r_mtime <= r_mtime + 64'd1;
      end
   end

   // Halves are written independently; there is no atomic 64-bit update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtimecmp <= '1;
      end else begin
         if (i_cmp_lo_we) r_mtimecmp[31:0]  <= i_wdata;
         if (i_cmp_hi_we) r_mtimecmp[63:32] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeh_snap <= '0;
      end else if (i_snap_re) begin
         r_timeh_snap <= r_mtime[63:32];
      end
   end

   // Compare uses the current register values, so the flag lags the
   // mtime/mtimecmp state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_leq <= 1'b0;
      end else begin
         r_leq <= (r_mtimecmp <= r_mtime);
      end
   end

   assign o_mtime_lo   = r_mtime[31:0];
   assign o_timeh_snap = r_timeh_snap;
   assign o_mtimecmp   = r_mtimecmp;
   assign o_leq        = r_leq;

endmodule

// File: rtl/trap_csr_unit.sv
// ---------------------------------------------------------------------------
// trap_csr_unit
// Machine-mode trap CSRs (mstatus.MIE/MPIE, mtvec, mepc, mcause) plus the
// interrupt sources (synchronized external interrupt, timer compare)
// consumed by the PC stage. Trap entry and mret commit on cpu_stat_pc.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_stat_pc             PC-update strobe (commit point)
//   csr_re/csr_we           CSR read strobe (timeh snapshot) / write enable
//   csr_adr/csr_wdata       CSR address / write data
//   csr_rdata               combinational read data, 0 when unmapped
//   ext_interrupt           asynchronous external interrupt level
//   ecall_condition_ex      ecall in EX
//   g_exception             illegal-instruction exception
//   cmd_mret_ex             mret in EX
//   interrupts_in_pc_state  PC stage taking an interrupt this strobe
//   pc_excep                return address [31:2] for mepc
//   csr_rmie                mstatus.MIE
//   g_interrupt             synchronized external interrupt level
//   g_interrupt_1shot       rising-edge pulse of g_interrupt
//   frc_cntr_val_leq        registered mtimecmp <= mtime
//   csr_mtvec_ex            mtvec[31:2]
//   csr_mepc_ex             mepc[31:2]
// ---------------------------------------------------------------------------
module trap_csr_unit
   import trap_csr_pkg::*;
#(
   parameter logic [29:0] MTVEC_INIT = 30'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_stat_pc,
   input  logic        csr_re,
   input  logic        csr_we,
   input  logic [11:0] csr_adr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic        ext_interrupt,
   input  logic        ecall_condition_ex,
   input  logic        g_exception,
   input  logic        cmd_mret_ex,
   input  logic        interrupts_in_pc_state,
   input  logic [29:0] pc_excep,
   output logic        csr_rmie,
   output logic        g_interrupt,
   output logic        g_interrupt_1shot,
   output logic        frc_cntr_val_leq,
   output logic [29:0] csr_mtvec_ex,
   output logic [29:0] csr_mepc_ex
);

   logic        r_mie;
   logic        r_mpie;
   logic [29:0] r_mtvec;
   logic [29:0] r_mepc;
   logic [31:0] r_mcause;
   logic        r_ext_pend;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync3;

   logic        w_trap;
   logic        w_mret;
   logic        w_int_entry;
   logic        w_oneshot;
   logic [31:0] w_cause;
   logic [31:0] w_rdata;
   logic        w_we_mstatus;
   logic        w_we_mtvec;
   logic        w_we_mepc;
   logic        w_we_mcause;
   logic        w_we_cmp_lo;
   logic        w_we_cmp_hi;
   logic        w_snap_re;
   logic [31:0] w_mtime_lo;
   logic [31:0] w_timeh_snap;
   logic [63:0] w_mtimecmp;
   logic        w_leq;

   // ------------------------------------------------------------------
   // Commit events and write decode
   // ------------------------------------------------------------------
   assign w_trap      = cpu_stat_pc & (g_exception | ecall_condition_ex | interrupts_in_pc_state);
   // Trap entry overrides an mret presented in the same strobe.
   assign w_mret      = cpu_stat_pc & cmd_mret_ex & ~w_trap;
   assign w_int_entry = cpu_stat_pc & interrupts_in_pc_state;

   assign w_we_mstatus = csr_we & (csr_adr == CSR_MSTATUS);
   assign w_we_mtvec   = csr_we & (csr_adr == CSR_MTVEC);
   assign w_we_mepc    = csr_we & (csr_adr == CSR_MEPC);
   assign w_we_mcause  = csr_we & (csr_adr == CSR_MCAUSE);
   assign w_we_cmp_lo  = csr_we & (csr_adr == CSR_MTIMECMP_LO);
   assign w_we_cmp_hi  = csr_we & (csr_adr == CSR_MTIMECMP_HI);
   assign w_snap_re    = csr_re & (csr_adr == CSR_TIME);

   // Cause priority: exception > ecall > external > timer.
   always_comb begin
      w_cause = INT_TIMER_M;
      if (g_exception)             w_cause = EXC_ILLEGAL;
      else if (ecall_condition_ex) w_cause = EXC_ECALL_M;
      else if (r_ext_pend)         w_cause = INT_EXT_M;
   end

   // ------------------------------------------------------------------
   // mstatus: trap entry > mret > CSR write
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mie  <= 1'b0;
         r_mpie <= 1'b0;
      end else if (w_trap) begin
         r_mpie <= r_mie;
         r_mie  <= 1'b0;
      end else if (w_mret) begin
         r_mie  <= r_mpie;
         r_mpie <= 1'b1;
      end else if (w_we_mstatus) begin
         r_mie  <= csr_wdata[MSTATUS_MIE_BIT];
         r_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
      end
   end

   // mtvec is never touched by a trap, so writes always land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mtvec <= MTVEC_INIT;
      end else if (w_we_mtvec) begin
         r_mtvec <= csr_wdata[31:2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mepc <= '0;
      end else if (w_trap) begin
         r_mepc <= pc_excep;
      end else if (w_we_mepc) begin
         r_mepc <= csr_wdata[31:2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcause <= '0;
      end else if (w_trap) begin
         r_mcause <= w_cause;
      end else if (w_we_mcause) begin
         r_mcause <= csr_wdata;
      end
   end

   // ------------------------------------------------------------------
   // External interrupt: 2-flop synchronizer plus one edge-detect flop
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= ext_interrupt;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_oneshot = r_sync2 & ~r_sync3;

   // Remembers that the pending interrupt came from the external source so
   // the cause can distinguish it from the timer at entry time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ext_pend <= 1'b0;
      end else if (w_int_entry) begin
         r_ext_pend <= 1'b0;
      end else if (w_oneshot & r_mie) begin
         r_ext_pend <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Timer
   // ------------------------------------------------------------------
   frc_timer u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmp_lo_we  (w_we_cmp_lo),
      .i_cmp_hi_we  (w_we_cmp_hi),
      .i_wdata      (csr_wdata),
      .i_snap_re    (w_snap_re),
      .o_mtime_lo   (w_mtime_lo),
      .o_timeh_snap (w_timeh_snap),
      .o_mtimecmp   (w_mtimecmp),
      .o_leq        (w_leq)
   );

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      case (csr_adr)
         CSR_MSTATUS:     w_rdata = mstatus_pack(r_mie, r_mpie);
         CSR_MTVEC:       w_rdata = {r_mtvec, 2'b00};
         CSR_MEPC:        w_rdata = {r_mepc, 2'b00};
         CSR_MCAUSE:      w_rdata = r_mcause;
         CSR_MTIMECMP_LO: w_rdata = w_mtimecmp[31:0];
         CSR_MTIMECMP_HI: w_rdata = w_mtimecmp[63:32];
         CSR_TIME:        w_rdata = w_mtime_lo;
         CSR_TIMEH:       w_rdata = w_timeh_snap;
         default:         w_rdata = '0;
      endcase
   end

   assign csr_rdata         = w_rdata;
   assign csr_rmie          = r_mie;
   assign g_interrupt       = r_sync2;
   assign g_interrupt_1shot = w_oneshot;
   assign frc_cntr_val_leq  = w_leq;
   assign csr_mtvec_ex      = r_mtvec;
   assign csr_mepc_ex       = r_mepc;

endmodule
